// File: rtl/exe_mem_excep_reg_pkg.sv
// Shared types for the EXE->MEM exception register: MIPS ExcCodes, access sizes,
// upstream flag bit positions and the squash state machine encoding.
package exe_mem_excep_reg_pkg;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C,
        EXC_TR   = 5'h0D
    } exccode_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } mem_size_t;

    // Bit positions inside exe_exc_flags_i = {fetch_adel, ri, syscall, brk, ov}
    localparam int EXC_FLAG_OV         = 0;
    localparam int EXC_FLAG_BRK        = 1;
    localparam int EXC_FLAG_SYSCALL    = 2;
    localparam int EXC_FLAG_RI         = 3;
    localparam int EXC_FLAG_FETCH_ADEL = 4;
    localparam int EXC_FLAG_W          = 5;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLOCK = 1'b1
    } state_t;

    // Reserved size 3 falls into the default arm and is checked like a word.
    function automatic logic addr_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/exe_mem_excep_reg_exc_prio_enc.sv
// Combinational exception priority encoder: folds every EXE-stage exception
// source into one ExcCode plus the matching BadVAddr.
module exc_prio_enc
    import exe_mem_excep_reg_pkg::*;
(
    input  logic                 valid,
    input  logic [EXC_FLAG_W-1:0] exc_flags,
    input  logic                 trap,
    input  logic                 int_pending,
    input  logic                 data_misaligned,
    input  logic                 data_is_store,
    input  logic [31:0]          pc,
    input  logic [31:0]          data_addr,
    output logic                 exc_valid,
    output exccode_t             exc_code,
    output logic [31:0]          badvaddr
);

    always_comb begin
        exc_valid = 1'b0;
        exc_code  = EXC_INT;
        badvaddr  = 32'h0;
        if (valid) begin
            exc_valid = 1'b1;
            if (int_pending) begin
                exc_code = EXC_INT;
            end else if (exc_flags[EXC_FLAG_FETCH_ADEL]) begin
                exc_code = EXC_ADEL;
                badvaddr = pc;
            end else if (exc_flags[EXC_FLAG_RI]) begin
                exc_code = EXC_RI;
            end else if (exc_flags[EXC_FLAG_SYSCALL]) begin
                exc_code = EXC_SYS;
            end else if (exc_flags[EXC_FLAG_BRK]) begin
                exc_code = EXC_BP;
            end else if (exc_flags[EXC_FLAG_OV]) begin
                exc_code = EXC_OV;
            end else if (trap) begin
                exc_code = EXC_TR;
            end else if (data_misaligned) begin
                exc_code = data_is_store ? EXC_ADES : EXC_ADEL;
                badvaddr = data_addr;
            end else begin
                exc_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/exe_mem_excep_reg.sv
// EXE->MEM pipeline register with exception resolution; after a faulting
// instruction is registered, younger instructions become bubbles until flush.
module exe_mem_excep_reg
    import exe_mem_excep_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid_i,
    input  logic [31:0] exe_pc_i,
    input  logic [31:0] exe_result_i,
    input  logic        exe_in_delay_slot_i,
    input  logic [4:0]  exe_exc_flags_i,
    input  logic        trap_valid_i,
    input  logic        int_pending_i,
    input  logic        exe_mem_re_i,
    input  logic        exe_mem_we_i,
    input  logic [1:0]  exe_mem_size_i,
    input  logic        mem_stall_i,
    input  logic        flush_i,
    output logic        exe_allowin_o,
    output logic        mem_valid_o,
    output logic [31:0] mem_pc_o,
    output logic [31:0] mem_result_o,
    output logic        mem_in_delay_slot_o,
    output logic        mem_mem_re_o,
    output logic        mem_mem_we_o,
    output logic [1:0]  mem_mem_size_o,
    output logic        mem_exc_valid_o,
    output logic [4:0]  mem_exc_code_o,
    output logic [31:0] mem_badvaddr_o
);

    state_t      state_reg;
    logic        valid_reg;
    logic [31:0] pc_reg;
    logic [31:0] result_reg;
    logic        ds_reg;
    logic        re_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        exc_valid_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] badvaddr_reg;

    logic        data_misaligned;
    logic        exc_valid;
    exccode_t    exc_code;
    logic [31:0] badvaddr;

    assign data_misaligned = (exe_mem_re_i || exe_mem_we_i)
                           && addr_misaligned(mem_size_t'(exe_mem_size_i), exe_result_i[1:0]);

    exc_prio_enc u_exc_prio_enc (
        .valid           (exe_valid_i),
        .exc_flags       (exe_exc_flags_i),
        .trap            (trap_valid_i),
        .int_pending     (int_pending_i),
        .data_misaligned (data_misaligned),
        .data_is_store   (exe_mem_we_i),
        .pc              (exe_pc_i),
        .data_addr       (exe_result_i),
        .exc_valid       (exc_valid),
        .exc_code        (exc_code),
        .badvaddr        (badvaddr)
    );

    assign exe_allowin_o = !mem_stall_i || flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            valid_reg     <= 1'b0;
            pc_reg        <= 32'h0;
            result_reg    <= 32'h0;
            ds_reg        <= 1'b0;
            re_reg        <= 1'b0;
            we_reg        <= 1'b0;
            size_reg      <= 2'd0;
            exc_valid_reg <= 1'b0;
            exc_code_reg  <= 5'h0;
            badvaddr_reg  <= 32'h0;
        end else if (flush_i) begin
            // Whatever EXE holds this cycle is younger than the flushing instruction.
            state_reg     <= ST_RUN;
            valid_reg     <= 1'b0;
            re_reg        <= 1'b0;
            we_reg        <= 1'b0;
            exc_valid_reg <= 1'b0;
        end else if (!mem_stall_i) begin
            pc_reg       <= exe_pc_i;
            result_reg   <= exe_result_i;
            ds_reg       <= exe_in_delay_slot_i;
            size_reg     <= exe_mem_size_i;
            exc_code_reg <= exc_code;
            badvaddr_reg <= badvaddr;
            if (exe_valid_i && state_reg == ST_RUN) begin
                valid_reg     <= 1'b1;
                exc_valid_reg <= exc_valid;
                re_reg        <= exe_mem_re_i && !exc_valid;
                we_reg        <= exe_mem_we_i && !exc_valid;
                if (exc_valid) begin
                    state_reg <= ST_BLOCK;
                end
            end else begin
                valid_reg     <= 1'b0;
                exc_valid_reg <= 1'b0;
                re_reg        <= 1'b0;
                we_reg        <= 1'b0;
            end
        end
    end

    assign mem_valid_o         = valid_reg;
    assign mem_pc_o            = pc_reg;
    assign mem_result_o        = result_reg;
    assign mem_in_delay_slot_o = ds_reg;
    assign mem_mem_re_o        = re_reg;
    assign mem_mem_we_o        = we_reg;
    assign mem_mem_size_o      = size_reg;
    assign mem_exc_valid_o     = exc_valid_reg;
    assign mem_exc_code_o      = exc_code_reg;
    assign mem_badvaddr_o      = badvaddr_reg;

endmodule

// File: tb/tb_exe_mem_excep_reg.sv
// Directed bench for exe_mem_excep_reg: the driver pushes hand-computed expected
// MEM outputs into a scoreboard queue; a negedge monitor pops and compares.
module tb_exe_mem_excep_reg;

    logic        clk;
    logic        rst;
    logic        exe_valid_i;
    logic [31:0] exe_pc_i;
    logic [31:0] exe_result_i;
    logic        exe_in_delay_slot_i;
    logic [4:0]  exe_exc_flags_i;
    logic        trap_valid_i;
    logic        int_pending_i;
    logic        exe_mem_re_i;
    logic        exe_mem_we_i;
    logic [1:0]  exe_mem_size_i;
    logic        mem_stall_i;
    logic        flush_i;
    logic        exe_allowin_o;
    logic        mem_valid_o;
    logic [31:0] mem_pc_o;
    logic [31:0] mem_result_o;
    logic        mem_in_delay_slot_o;
    logic        mem_mem_re_o;
    logic        mem_mem_we_o;
    logic [1:0]  mem_mem_size_o;
    logic        mem_exc_valid_o;
    logic [4:0]  mem_exc_code_o;
    logic [31:0] mem_badvaddr_o;

    exe_mem_excep_reg dut (
        .clk                 (clk),
        .rst                 (rst),
        .exe_valid_i         (exe_valid_i),
        .exe_pc_i            (exe_pc_i),
        .exe_result_i        (exe_result_i),
        .exe_in_delay_slot_i (exe_in_delay_slot_i),
        .exe_exc_flags_i     (exe_exc_flags_i),
        .trap_valid_i        (trap_valid_i),
        .int_pending_i       (int_pending_i),
        .exe_mem_re_i        (exe_mem_re_i),
        .exe_mem_we_i        (exe_mem_we_i),
        .exe_mem_size_i      (exe_mem_size_i),
        .mem_stall_i         (mem_stall_i),
        .flush_i             (flush_i),
        .exe_allowin_o       (exe_allowin_o),
        .mem_valid_o         (mem_valid_o),
        .mem_pc_o            (mem_pc_o),
        .mem_result_o        (mem_result_o),
        .mem_in_delay_slot_o (mem_in_delay_slot_o),
        .mem_mem_re_o        (mem_mem_re_o),
        .mem_mem_we_o        (mem_mem_we_o),
        .mem_mem_size_o      (mem_mem_size_o),
        .mem_exc_valid_o     (mem_exc_valid_o),
        .mem_exc_code_o      (mem_exc_code_o),
        .mem_badvaddr_o      (mem_badvaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] res;
        logic        ds;
        logic [4:0]  fl;
        logic        tr;
        logic        ip;
        logic        re;
        logic        we;
        logic [1:0]  sz;
        logic        st;
        logic        fs;
        logic        rs;
    } stim_t;

    // full = 0 marks a bubble, where only the control bits are defined.
    typedef struct packed {
        logic        full;
        logic        v;
        logic        xv;
        logic [4:0]  code;
        logic [31:0] bad;
        logic        re;
        logic        we;
        logic [31:0] pc;
        logic [31:0] res;
        logic [1:0]  sz;
        logic        ds;
        logic        allow;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic stim_t s_in(input int v, input int pc, input int res, input int fl,
                                   input int tr, input int ip, input int re, input int we, input int sz);
        stim_t s;
        s    = '0;
        s.v  = v[0];
        s.pc = pc;
        s.res = res;
        s.fl = fl[4:0];
        s.tr = tr[0];
        s.ip = ip[0];
        s.re = re[0];
        s.we = we[0];
        s.sz = sz[1:0];
        return s;
    endfunction

    function automatic exp_t e_ok(input int pc, input int res, input int re, input int we, input int sz);
        exp_t e;
        e       = '0;
        e.full  = 1'b1;
        e.v     = 1'b1;
        e.pc    = pc;
        e.res   = res;
        e.re    = re[0];
        e.we    = we[0];
        e.sz    = sz[1:0];
        e.allow = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_exc(input int pc, input int res, input int sz, input int code, input int bad);
        exp_t e;
        e       = e_ok(pc, res, 0, 0, sz);
        e.xv    = 1'b1;
        e.code  = code[4:0];
        e.bad   = bad;
        return e;
    endfunction

    function automatic exp_t e_bub();
        exp_t e;
        e       = '0;
        e.allow = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_rst();
        exp_t e;
        e       = '0;
        e.full  = 1'b1;
        e.allow = 1'b1;
        return e;
    endfunction

    // Drive one cycle of stimulus, check the combinational handshake, then
    // queue what MEM must show after the edge.
    task automatic go(input stim_t s, input exp_t e);
        rst                 = s.rs;
        exe_valid_i         = s.v;
        exe_pc_i            = s.pc;
        exe_result_i        = s.res;
        exe_in_delay_slot_i = s.ds;
        exe_exc_flags_i     = s.fl;
        trap_valid_i        = s.tr;
        int_pending_i       = s.ip;
        exe_mem_re_i        = s.re;
        exe_mem_we_i        = s.we;
        exe_mem_size_i      = s.sz;
        mem_stall_i         = s.st;
        flush_i             = s.fs;
        #1;
        check("allowin", 32'(exe_allowin_o), 32'(e.allow));
        @(posedge clk);
        #1;
        sb_q.push_back(e);
    endtask

    task automatic flush_cycle();
        stim_t s;
        s    = '0;
        s.fs = 1'b1;
        go(s, e_bub());
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_txn++;
            $display("txn %0d: valid=%0b exc=%0b code=0x%02h bad=0x%08h re=%0b we=%0b pc=0x%08h",
                     n_txn, mem_valid_o, mem_exc_valid_o, mem_exc_code_o, mem_badvaddr_o,
                     mem_mem_re_o, mem_mem_we_o, mem_pc_o);
            check("mem_valid", 32'(mem_valid_o), 32'(e.v));
            check("exc_valid", 32'(mem_exc_valid_o), 32'(e.xv));
            check("mem_re", 32'(mem_mem_re_o), 32'(e.re));
            check("mem_we", 32'(mem_mem_we_o), 32'(e.we));
            if (e.full) begin
                check("exc_code", 32'(mem_exc_code_o), 32'(e.code));
                check("badvaddr", mem_badvaddr_o, e.bad);
                check("pc", mem_pc_o, e.pc);
                check("result", mem_result_o, e.res);
                check("size", 32'(mem_mem_size_o), 32'(e.sz));
                check("delay_slot", 32'(mem_in_delay_slot_o), 32'(e.ds));
            end
        end
    end

    initial begin
        stim_t s;
        exp_t  e;
        exp_t  held;

        rst = 1'b1; exe_valid_i = 1'b0; exe_pc_i = '0; exe_result_i = '0;
        exe_in_delay_slot_i = 1'b0; exe_exc_flags_i = '0; trap_valid_i = 1'b0;
        int_pending_i = 1'b0; exe_mem_re_i = 1'b0; exe_mem_we_i = 1'b0;
        exe_mem_size_i = '0; mem_stall_i = 1'b0; flush_i = 1'b0;
        @(posedge clk);
        #1;

        s = '0; s.rs = 1'b1;
        go(s, e_rst());

        // Clean word load in a delay slot
        s = s_in(1, 32'h8000_0000, 32'h8000_0004, 0, 0, 0, 1, 0, 2); s.ds = 1'b1;
        e = e_ok(32'h8000_0000, 32'h8000_0004, 1, 0, 2); e.ds = 1'b1;
        go(s, e);

        // Trap, then three squashed followers, flush (with a faulting instr dropped), then pass
        go(s_in(1, 32'hBFC0_0100, 32'h1234, 0, 1, 0, 0, 0, 2), e_exc(32'hBFC0_0100, 32'h1234, 2, 5'h0D, 0));
        for (int i = 0; i < 3; i++)
            go(s_in(1, 32'h100 + 4 * i, 32'h2000, 0, 0, 0, 1, 0, 2), e_bub());
        s = s_in(1, 32'h110, 32'h0, 0, 1, 0, 0, 0, 2); s.fs = 1'b1;
        go(s, e_bub());
        go(s_in(1, 32'h114, 32'h5, 0, 0, 0, 0, 0, 2), e_ok(32'h114, 32'h5, 0, 0, 2));

        // Alignment
        go(s_in(1, 32'h200, 32'h1001, 0, 0, 0, 0, 1, 1), e_exc(32'h200, 32'h1001, 1, 5'h05, 32'h1001));
        flush_cycle();
        go(s_in(1, 32'h204, 32'h1002, 0, 0, 0, 1, 0, 2), e_exc(32'h204, 32'h1002, 2, 5'h04, 32'h1002));
        flush_cycle();
        go(s_in(1, 32'h208, 32'h1003, 0, 0, 0, 1, 0, 0), e_ok(32'h208, 32'h1003, 1, 0, 0));
        go(s_in(1, 32'h20C, 32'h1004, 0, 0, 0, 0, 1, 3), e_ok(32'h20C, 32'h1004, 0, 1, 3));
        go(s_in(1, 32'h210, 32'h1006, 0, 0, 0, 1, 0, 3), e_exc(32'h210, 32'h1006, 3, 5'h04, 32'h1006));
        flush_cycle();
        go(s_in(1, 32'h214, 32'h1002, 0, 0, 0, 1, 0, 1), e_ok(32'h214, 32'h1002, 1, 0, 1));

        // Priority among simultaneous sources
        go(s_in(1, 32'h220, 32'h3, 5'b01001, 1, 0, 1, 0, 2), e_exc(32'h220, 32'h3, 2, 5'h0A, 0));
        flush_cycle();
        go(s_in(1, 32'h0040_0003, 32'h0, 5'b10000, 0, 1, 0, 0, 2), e_exc(32'h0040_0003, 32'h0, 2, 5'h00, 0));
        flush_cycle();
        go(s_in(1, 32'h0040_0002, 32'h7, 5'b10000, 0, 0, 0, 1, 2),
           e_exc(32'h0040_0002, 32'h7, 2, 5'h04, 32'h0040_0002));
        flush_cycle();
        go(s_in(1, 32'h230, 32'h0, 5'b00110, 0, 0, 0, 0, 2), e_exc(32'h230, 32'h0, 2, 5'h08, 0));
        flush_cycle();
        go(s_in(1, 32'h234, 32'h0, 5'b00011, 0, 0, 0, 0, 2), e_exc(32'h234, 32'h0, 2, 5'h09, 0));
        flush_cycle();
        go(s_in(1, 32'h238, 32'h0, 5'b00001, 1, 0, 0, 0, 2), e_exc(32'h238, 32'h0, 2, 5'h0C, 0));
        flush_cycle();
        go(s_in(1, 32'h23C, 32'h5, 0, 1, 0, 1, 0, 2), e_exc(32'h23C, 32'h5, 2, 5'h0D, 0));
        flush_cycle();

        // Interrupt with no instruction is ignored; the next valid one takes it
        go(s_in(0, 32'h300, 32'h0, 0, 0, 1, 1, 0, 2), e_bub());
        go(s_in(1, 32'h304, 32'h8, 0, 0, 1, 1, 0, 2), e_exc(32'h304, 32'h8, 2, 5'h00, 0));
        flush_cycle();

        // Stall freezes everything; flush overrides the stall
        held = e_ok(32'h400, 32'h8000_0010, 1, 0, 2);
        go(s_in(1, 32'h400, 32'h8000_0010, 0, 0, 0, 1, 0, 2), held);
        for (int i = 0; i < 3; i++) begin
            s = s_in(1, 32'h404 + 4 * i, 32'h9 + i, 5'b00001, 1, 0, 0, 1, 1); s.st = 1'b1;
            e = held; e.allow = 1'b0;
            go(s, e);
        end
        s = s_in(1, 32'h410, 32'h20, 0, 0, 0, 1, 0, 2); s.st = 1'b1; s.fs = 1'b1;
        go(s, e_bub());

        // Reset while blocked, with flush and stall also high
        go(s_in(1, 32'h500, 32'h0, 0, 1, 0, 0, 0, 2), e_exc(32'h500, 32'h0, 2, 5'h0D, 0));
        s = s_in(1, 32'h504, 32'h44, 5'b00100, 1, 0, 1, 0, 2); s.st = 1'b1; s.fs = 1'b1; s.rs = 1'b1;
        go(s, e_rst());
        go(s_in(1, 32'h508, 32'h8000_0020, 0, 0, 0, 1, 0, 2), e_ok(32'h508, 32'h8000_0020, 1, 0, 2));

        s = '0;
        go(s, e_bub());
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exe_mem_excep_reg.md
# exe_mem_excep_reg

EXE→MEM pipeline register that consumes the trap-detect result and all other per-instruction exception sources of the execute stage. It performs the data-address alignment check, resolves exception priority into one MIPS ExcCode plus BadVAddr, and gates memory side effects of faulting instructions. Once a faulting instruction has been registered, it squashes younger instructions until the commit-side flush arrives.

## Interface
- No parameters.
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `exe_valid_i`  in  1  EXE holds a real instruction
- `exe_pc_i`  in  32  instruction PC
- `exe_result_i`  in  32  ALU result / effective memory address
- `exe_in_delay_slot_i`  in  1  instruction is in a branch delay slot
- `exe_exc_flags_i`  in  5  upstream exceptions `{fetch_adel, ri, syscall, brk, ov}`
- `trap_valid_i`  in  1  trap condition from the EXE trap-detect unit
- `int_pending_i`  in  1  CP0 interrupt pending and enabled
- `exe_mem_re_i` / `exe_mem_we_i`  in  1  load / store
- `exe_mem_size_i`  in  2  0 = byte, 1 = half, 2 = word
- `mem_stall_i`  in  1  MEM cannot accept; hold the register
- `flush_i`  in  1  commit-side exception/ERET flush
- `exe_allowin_o`  out  1  EXE may hand over this cycle
- `mem_valid_o`, `mem_pc_o[31:0]`, `mem_result_o[31:0]`, `mem_in_delay_slot_o`  out  registered copies
- `mem_mem_re_o`, `mem_mem_we_o`  out  1  registered; forced 0 when the exception is set
- `mem_mem_size_o`  out  2  registered
- `mem_exc_valid_o`  out  1  registered instruction faults
- `mem_exc_code_o`  out  5  MIPS ExcCode
- `mem_badvaddr_o`  out  32  faulting address; 0 if not an address error

## Operation
**Alignment check**
- Half access misaligned if `addr[0]`.
- Word access misaligned if `addr[1:0] != 0`.
- Byte access is never misaligned.
- Size 3 is treated as word.
- Misaligned load gives AdEL (0x04); misaligned store gives AdES (0x05).

**Priority** (highest first), applied only when `exe_valid_i`:
- Int 0x00
- fetch AdEL 0x04 (BadVAddr = `exe_pc_i`)
- RI 0x0A
- Sys 0x08
- Bp 0x09
- Ov 0x0C
- Tr 0x0D
- data AdEL/AdES (BadVAddr = `exe_result_i`)

**State machine**
- States: `RUN`, `BLOCK`.
- RUN: accepted instructions are registered normally. If the accepted instruction faults, go to BLOCK.
- BLOCK: accepted instructions are discarded; a bubble (`mem_valid_o` = 0) is written. Stay until `flush_i`, then go to RUN.

**Handshake and register update**
- `exe_allowin_o = !mem_stall_i || flush_i`.
- Update when `exe_allowin_o`. A bubble is loaded when `!exe_valid_i`.
- With `mem_stall_i` and no flush, all outputs and the state hold.
- `flush_i` beats `mem_stall_i` and `exe_valid_i`: `mem_valid_o` ← 0, `mem_exc_valid_o` ← 0, state ← RUN.
- Bubble: `mem_valid_o`, `mem_exc_valid_o`, `mem_mem_re_o`, `mem_mem_we_o` = 0. Data fields may hold stale values.

## Timing
- Latency is 1 cycle from EXE inputs to MEM outputs. All outputs are registered except `exe_allowin_o`, which is combinational.
- Reset: all registered outputs 0, `mem_exc_code_o` = 0, state = RUN. Reset beats flush and stall.
- Reset mid-BLOCK returns to RUN with a bubble.
- An instruction that faults in the same cycle as `flush_i` is dropped.
- Interrupt with `!exe_valid_i` is ignored; the next valid instruction takes it.
- Multiple sources in one instruction: only the highest-priority code is reported. BadVAddr follows the winning source.

## Structure
- Shared package: `exccode_t` enum (INT, ADEL, ADES, SYS, BP, RI, OV, TR); `mem_size_t`; `EXC_FLAG_*` bit indices for `exe_flags`; state enum.
- One combinational sub-module, `exc_prio_enc`: takes the flags, trap, int, alignment result and addresses; returns `{exc_valid, exc_code, badvaddr}`.
- State, handshake and pipeline registers stay in the top.

## Test plan
- Reset, then a valid word load at `0x8000_0004`, no flags → next cycle `mem_valid_o` = 1, `mem_mem_re_o` = 1, `mem_exc_valid_o` = 0.
- `trap_valid_i` = 1 with `pc` = `0xBFC0_0100` → `mem_exc_code_o` = 0x0D, `mem_badvaddr_o` = 0. Next three valid inputs register as bubbles until `flush_i`, after which the fourth passes.
- Half store at `0x1001` → code 0x05, `mem_badvaddr_o` = `0x1001`, `mem_mem_we_o` = 0. Word load at `0x1002` → 0x04.
- `ri` + `ov` + `trap` together → 0x0A. `fetch_adel` + `int_pending` → 0x00.
- `mem_stall_i` held for 3 cycles with changing inputs → outputs frozen, `exe_allowin_o` = 0. `flush_i` during the stall → bubble next cycle.
- `rst` asserted while in BLOCK together with `flush_i` and `mem_stall_i` → all outputs 0, state RUN; the next valid instruction registers normally.
